// File: rtl/sem_wr_arbiter.sv
// Round-robin arbiter that lets N writers share one single-bit semaphore mailbox.
// Holds a tag naming the posted writer until the reader consumes the bit.
module sem_wr_arbiter #(
  parameter int N    = 4,
  parameter int TAGW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    req_di_i,
  input  logic            sem_wr_rdy_i,
  input  logic            sem_rd_done_i,
  output logic            sem_wr_o,
  output logic            sem_di_o,
  output logic [N-1:0]    gnt_o,
  output logic [TAGW-1:0] tag_o,
  output logic            tag_vld_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  localparam logic [TAGW:0]   NW   = (TAGW+1)'(N);
  localparam logic [TAGW-1:0] LAST = TAGW'(N-1);

  state_e          state_q, state_d;
  logic [TAGW-1:0] ptr_q, ptr_d;
  logic [TAGW-1:0] sel_q, sel_d;
  logic            dat_q, dat_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            vld_q, vld_d;

  logic [TAGW:0]   idx;
  logic [TAGW-1:0] win;
  logic            found;

  // Search starts at ptr_q and wraps modulo N, never past N-1.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (TAGW+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!found && req_i[idx[TAGW-1:0]]) begin
        found = 1'b1;
        win   = idx[TAGW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    gnt_d   = '0;
    tag_d   = tag_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          dat_d   = req_di_i[win];
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (sem_wr_rdy_i) begin
          gnt_d[sel_q] = 1'b1;
          tag_d        = sel_q;
          vld_d        = 1'b1;
          ptr_d        = (sel_q == LAST) ? '0 : sel_q + TAGW'(1);
          state_d      = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (sem_rd_done_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= 1'b0;
      gnt_q   <= '0;
      tag_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      gnt_q   <= gnt_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
    end
  end

  // Reset gating keeps the mailbox from capturing a write on the reset edge.
  assign sem_wr_o  = (state_q == WRITE) & ~rst_i;
  assign sem_di_o  = dat_q & ~rst_i;
  assign busy_o    = (state_q != IDLE) & ~rst_i;
  assign gnt_o     = gnt_q;
  assign tag_o     = tag_q;
  assign tag_vld_o = vld_q;

endmodule
